// File: rtl/sy_axi_mem_slave.sv
// AXI4 slave memory responder: one read or write burst at a time
// from a word-addressed array with byte strobes.
package axi_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

endpackage

module sy_axi_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 65536,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned DATA_WTH  = 64
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     inp_axi_aw_valid_i,
  output logic     inp_axi_aw_ready_o,
  input  aw_chan_t inp_axi_aw_bits_i,
  input  logic     inp_axi_w_valid_i,
  output logic     inp_axi_w_ready_o,
  input  w_chan_t  inp_axi_w_bits_i,
  output logic     inp_axi_b_valid_o,
  input  logic     inp_axi_b_ready_i,
  output b_chan_t  inp_axi_b_bits_o,
  input  logic     inp_axi_ar_valid_i,
  output logic     inp_axi_ar_ready_o,
  input  ar_chan_t inp_axi_ar_bits_i,
  output logic     inp_axi_r_valid_o,
  input  logic     inp_axi_r_ready_i,
  output r_chan_t  inp_axi_r_bits_o
);

  localparam int unsigned IW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned NB = DATA_WTH / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic RR_READ  = 1'b0;
  localparam logic RR_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_DATA
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  id_q;
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [1:0]  err_q;
  logic        rr_last;
  r_chan_t     r_q;
  r_chan_t     r_nxt;

  logic [DATA_WTH-1:0] mem [MEM_DEPTH];

  logic          grant_w, grant_r;
  logic          aw_hs, ar_hs, w_hs, r_hs;
  logic          beat_end;
  logic [63:0]   rd_addr;
  logic [2:0]    rd_size;
  logic          rd_last;
  logic [1:0]    rd_resp;
  logic [1:0]    wr_resp;
  logic [1:0]    wr_err;
  logic [IW-1:0] rd_idx, wr_idx;

  function automatic logic [63:0] next_addr(
    input logic [63:0] a,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [63:0] step, win, inc, res;
    step = 64'd1 << size;
    win  = (64'(len) + 64'd1) << size;
    inc  = a + step;
    unique case (1'b1)
      burst == 2'b00: res = a;
      burst == 2'b10: res = (a & ~(win - 64'd1)) | (inc & (win - 64'd1));
      default:        res = inc;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] beat_resp(
    input logic [63:0] a,
    input logic [2:0]  size
  );
    logic [1:0] res;
    res = OKAY;
    if (size > 3'd3)
      res = SLVERR;
    else if (a < BASE_ADDR ||
             ((a - BASE_ADDR) >> 3) >= 64'(MEM_DEPTH))
      res = DECERR;
    return res;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [63:0] a);
    logic [63:0] off;
    off = (a - BASE_ADDR) >> 3;
    return off[IW-1:0];
  endfunction

  // Both requesting: grant the channel that did not win last time
  assign grant_w = inp_axi_aw_valid_i &&
                   (!inp_axi_ar_valid_i || rr_last == RR_READ);
  assign grant_r = inp_axi_ar_valid_i && !grant_w;

  assign aw_hs    = state == IDLE && grant_w;
  assign ar_hs    = state == IDLE && grant_r;
  assign w_hs     = state == WR_DATA && inp_axi_w_valid_i;
  assign r_hs     = state == RD_DATA && inp_axi_r_ready_i;
  assign beat_end = beat_cnt == len_q;

  always_comb begin
    rd_addr = next_addr(addr_q, len_q, size_q, burst_q);
    rd_size = size_q;
    rd_last = (beat_cnt + 8'd1) == len_q;
    if (state == IDLE) begin
      rd_addr = inp_axi_ar_bits_i.addr;
      rd_size = inp_axi_ar_bits_i.size;
      rd_last = inp_axi_ar_bits_i.len == 8'd0;
    end
    rd_resp = beat_resp(rd_addr, rd_size);
    rd_idx  = word_idx(rd_addr);
    wr_resp = beat_resp(addr_q, size_q);
    wr_idx  = word_idx(addr_q);
    wr_err  = wr_resp;
    if (inp_axi_w_bits_i.last != beat_end && wr_resp < SLVERR)
      wr_err = SLVERR;
    r_nxt.id   = (state == IDLE) ? inp_axi_ar_bits_i.id : id_q;
    r_nxt.data = (rd_resp == OKAY) ? mem[rd_idx] : '0;
    r_nxt.resp = rd_resp;
    r_nxt.last = rd_last;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      err_q    <= OKAY;
      rr_last  <= RR_READ;
      r_q      <= '0;
    end else begin
      state <= state_nxt;
      if (aw_hs) begin
        id_q     <= inp_axi_aw_bits_i.id;
        addr_q   <= inp_axi_aw_bits_i.addr;
        len_q    <= inp_axi_aw_bits_i.len;
        size_q   <= inp_axi_aw_bits_i.size;
        burst_q  <= inp_axi_aw_bits_i.burst;
        beat_cnt <= '0;
        err_q    <= OKAY;
        rr_last  <= RR_WRITE;
      end
      if (ar_hs) begin
        id_q     <= inp_axi_ar_bits_i.id;
        addr_q   <= inp_axi_ar_bits_i.addr;
        len_q    <= inp_axi_ar_bits_i.len;
        size_q   <= inp_axi_ar_bits_i.size;
        burst_q  <= inp_axi_ar_bits_i.burst;
        beat_cnt <= '0;
        rr_last  <= RR_READ;
        r_q      <= r_nxt;
      end
      if (w_hs) begin
        addr_q   <= next_addr(addr_q, len_q, size_q, burst_q);
        beat_cnt <= beat_cnt + 8'd1;
        if (wr_err > err_q)
          err_q <= wr_err;
      end
      // Prefetch the next beat so a held r_ready streams 1 beat/cycle
      if (r_hs && !beat_end) begin
        addr_q   <= rd_addr;
        beat_cnt <= beat_cnt + 8'd1;
        r_q      <= r_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs && wr_resp == OKAY) begin
      for (int b = 0; b < NB; b++) begin
        if (inp_axi_w_bits_i.strb[b])
          mem[wr_idx][8*b +: 8] <= inp_axi_w_bits_i.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_w)
          state_nxt = WR_DATA;
        else if (grant_r)
          state_nxt = RD_DATA;
      end
      WR_DATA: begin
        if (inp_axi_w_valid_i && beat_end)
          state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (inp_axi_b_ready_i)
          state_nxt = IDLE;
      end
      RD_DATA: begin
        if (inp_axi_r_ready_i && beat_end)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inp_axi_aw_ready_o = aw_hs;
    inp_axi_ar_ready_o = ar_hs;
    inp_axi_w_ready_o  = state == WR_DATA;
    inp_axi_b_valid_o  = state == WR_RESP;
    inp_axi_b_bits_o   = '{id: id_q, resp: err_q};
    inp_axi_r_valid_o  = state == RD_DATA;
    inp_axi_r_bits_o   = r_q;
  end

endmodule

// File: tb/tb_sy_axi_mem_slave.sv
// Randomized self-checking bench for sy_axi_mem_slave against
// a byte-level memory model with per-beat address arithmetic.
module tb_sy_axi_mem_slave;
  import axi_pkg::*;

  typedef longint unsigned u64;

  localparam int unsigned DEPTH = 65536;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     aw_valid = 1'b0, aw_ready;
  aw_chan_t aw_bits = '0;
  logic     w_valid = 1'b0, w_ready;
  w_chan_t  w_bits = '0;
  logic     b_valid, b_ready = 1'b0;
  b_chan_t  b_bits;
  logic     ar_valid = 1'b0, ar_ready;
  ar_chan_t ar_bits = '0;
  logic     r_valid, r_ready = 1'b0;
  r_chan_t  r_bits;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mdl [u64];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];

  always #5 clk = ~clk;

  sy_axi_mem_slave #(
    .MEM_DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .DATA_WTH(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .inp_axi_aw_valid_i(aw_valid),
    .inp_axi_aw_ready_o(aw_ready),
    .inp_axi_aw_bits_i(aw_bits),
    .inp_axi_w_valid_i(w_valid),
    .inp_axi_w_ready_o(w_ready),
    .inp_axi_w_bits_i(w_bits),
    .inp_axi_b_valid_o(b_valid),
    .inp_axi_b_ready_i(b_ready),
    .inp_axi_b_bits_o(b_bits),
    .inp_axi_ar_valid_i(ar_valid),
    .inp_axi_ar_ready_o(ar_ready),
    .inp_axi_ar_bits_i(ar_bits),
    .inp_axi_r_valid_o(r_valid),
    .inp_axi_r_ready_i(r_ready),
    .inp_axi_r_bits_o(r_bits)
  );

  function automatic u64 beat_addr(aw_chan_t c, int i);
    u64 a, step, win, lower;
    a = c.addr;
    step = u64'(1) << c.size;
    win = (u64'(c.len) + 1) * step;
    case (c.burst)
      2'b00: return a;
      2'b10: begin
        lower = (a / win) * win;
        return lower + ((a - lower) + u64'(i) * step) % win;
      end
      default: return a + u64'(i) * step;
    endcase
  endfunction

  function automatic logic [1:0] exp_resp(u64 a, logic [2:0] size);
    if (size > 3) return 2'b10;
    if (a < BASE || ((a - BASE) / 8) >= DEPTH) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [63:0] mrd(u64 a);
    u64 k;
    k = (a - BASE) / 8;
    return mdl.exists(k) ? mdl[k] : 64'd0;
  endfunction

  function automatic logic [1:0] model_w(aw_chan_t c, int i);
    u64 a;
    logic [63:0] w;
    logic [1:0] r;
    a = beat_addr(c, i);
    r = exp_resp(a, c.size);
    if (r == 2'b00) begin
      w = mrd(a);
      for (int b = 0; b < 8; b++)
        if (wstb[i][b]) w[8*b +: 8] = wdat[i][8*b +: 8];
      mdl[(a - BASE) / 8] = w;
    end
    return r;
  endfunction

  function automatic aw_chan_t mk(int id, u64 a, int len,
                                  int size, int burst);
    aw_chan_t c;
    c.id = 4'(id);
    c.addr = a;
    c.len = 8'(len);
    c.size = 3'(size);
    c.burst = 2'(burst);
    return c;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    b_ready = 0; r_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic aw_hs(input aw_chan_t c);
    int n;
    aw_valid = 1; aw_bits = c; #1;
    n = 0;
    while (aw_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      miscompares++;
      $display("FAIL aw_timeout got ready=%b want 1", aw_ready);
    end
    @(negedge clk);
    aw_valid = 0;
  endtask

  task automatic ar_hs(input aw_chan_t c);
    int n;
    ar_valid = 1; ar_bits = ar_chan_t'(c); #1;
    n = 0;
    while (ar_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      miscompares++;
      $display("FAIL ar_timeout got ready=%b want 1", ar_ready);
    end
    @(negedge clk);
    ar_valid = 0;
  endtask

  task automatic w_phase(input aw_chan_t c, input int bad);
    logic [1:0] exp, r;
    logic lst;
    int n;
    exp = 2'b00;
    for (int i = 0; i <= int'(c.len); i++) begin
      lst = (i == int'(c.len)) ^ (i == bad);
      r = model_w(c, i);
      if (lst != (i == int'(c.len)) && r < 2'b10) r = 2'b10;
      if (r > exp) exp = r;
      w_valid = 1;
      w_bits = '{data: wdat[i], strb: wstb[i], last: lst};
      #1; n = 0;
      while (w_ready !== 1'b1 && n < 50) begin
        @(negedge clk); #1; n++;
      end
      if (n >= 50) begin
        miscompares++;
        $display("FAIL w_timeout beat %0d got ready=%b want 1", i, w_ready);
      end
      @(negedge clk);
    end
    w_valid = 0;
    vectors++;
    if (b_valid !== 1'b1 || b_bits.id !== c.id || b_bits.resp !== exp) begin
      miscompares++;
      $display("FAIL bresp got v=%b id=%h resp=%b want v=1 id=%h resp=%b",
               b_valid, b_bits.id, b_bits.resp, c.id, exp);
    end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
  endtask

  task automatic r_phase(input aw_chan_t c, input int stall);
    r_chan_t snap;
    u64 a;
    logic [63:0] ed;
    logic [1:0] er;
    logic el;
    int n;
    vectors++;
    if (r_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL r_latency got r_valid=%b want 1", r_valid);
    end
    for (int i = 0; i <= int'(c.len); i++) begin
      if (i == stall) begin
        r_ready = 0; #1;
        snap = r_bits;
        repeat (5) begin
          @(negedge clk);
          vectors++;
          if (r_valid !== 1'b1 || r_bits !== snap) begin
            miscompares++;
            $display("FAIL r_stall got v=%b bits=%h want v=1 bits=%h",
                     r_valid, r_bits, snap);
          end
        end
      end
      r_ready = 1; n = 0;
      while (r_valid !== 1'b1 && n < 50) begin
        @(negedge clk); n++;
      end
      a = beat_addr(c, i);
      er = exp_resp(a, c.size);
      ed = (er == 2'b00) ? mrd(a) : 64'd0;
      el = (i == int'(c.len));
      vectors++;
      if (r_valid !== 1'b1 || r_bits.id !== c.id || r_bits.data !== ed ||
          r_bits.resp !== er || r_bits.last !== el) begin
        miscompares++;
        $display("FAIL rbeat%0d got v=%b id=%h d=%h resp=%b last=%b want v=1 id=%h d=%h resp=%b last=%b",
                 i, r_valid, r_bits.id, r_bits.data, r_bits.resp,
                 r_bits.last, c.id, ed, er, el);
      end
      @(negedge clk);
    end
    r_ready = 0;
    vectors++;
    if (r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL r_end got r_valid=%b want 0", r_valid);
    end
  endtask

  task automatic wr_burst(input aw_chan_t c, input int bad);
    aw_hs(c);
    w_phase(c, bad);
  endtask

  task automatic rd_burst(input aw_chan_t c, input int stall);
    ar_hs(c);
    r_phase(c, stall);
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({aw_ready, w_ready, b_valid, ar_ready, r_valid} !== 5'b0 ||
        b_bits !== '0 || r_bits !== '0) begin
      miscompares++;
      $display("FAIL %s got rdy/val=%b b=%h r=%h want all 0", tag,
               {aw_ready, w_ready, b_valid, ar_ready, r_valid},
               b_bits, r_bits);
    end
  endtask

  task automatic test_reset;
    #1;
    check_idle_outputs("reset_hold");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_basic;
    aw_chan_t c;
    c = mk(3, BASE, 3, 3, 1);
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 64'h11 * u64'(i + 1);
      wstb[i] = 8'hFF;
    end
    wr_burst(c, -1);
    rd_burst(c, -1);
  endtask

  task automatic test_fill;
    aw_chan_t c;
    c = mk(1, BASE, 255, 3, 1);
    for (int i = 0; i < 256; i++) begin
      wdat[i] = {$urandom, $urandom};
      wstb[i] = 8'hFF;
    end
    wr_burst(c, -1);
    rd_burst(c, 100);
  endtask

  task automatic test_strobe;
    aw_chan_t c;
    c = mk(2, BASE + 8 * 70, 0, 3, 1);
    wdat[0] = 64'd0; wstb[0] = 8'hFF;
    wr_burst(c, -1);
    wdat[0] = 64'hAABBCCDD_EEFF0011; wstb[0] = 8'h0F;
    wr_burst(c, -1);
    rd_burst(c, -1);
  endtask

  task automatic test_arb;
    aw_chan_t cw, cr;
    logic exp_w;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      cw = mk(k, BASE + 8 * (20 + k), 0, 3, 1);
      cr = mk(k + 8, BASE + 8 * (20 + k), 0, 3, 1);
      wdat[0] = {$urandom, $urandom}; wstb[0] = 8'hFF;
      aw_valid = 1; aw_bits = cw;
      ar_valid = 1; ar_bits = ar_chan_t'(cr);
      #1;
      exp_w = (k % 2 == 0);
      vectors++;
      if (aw_ready !== exp_w || ar_ready !== !exp_w) begin
        miscompares++;
        $display("FAIL arb%0d got aw_rdy=%b ar_rdy=%b want %b %b",
                 k, aw_ready, ar_ready, exp_w, !exp_w);
      end
      @(negedge clk);
      aw_valid = 0; ar_valid = 0;
      if (exp_w) w_phase(cw, -1);
      else r_phase(cr, -1);
    end
  endtask

  task automatic test_wrap;
    aw_chan_t c;
    c = mk(6, BASE + 64'h18, 3, 3, 2);
    rd_burst(c, -1);
    c = mk(7, BASE + 64'h48, 7, 3, 2);
    for (int i = 0; i < 8; i++) begin
      wdat[i] = {$urandom, $urandom}; wstb[i] = 8'(($urandom));
    end
    wr_burst(c, -1);
    rd_burst(mk(7, BASE + 64'h40, 7, 3, 1), -1);
  endtask

  task automatic test_errors;
    aw_chan_t c;
    c = mk(5, BASE + u64'(DEPTH) * 8, 1, 3, 1);
    rd_burst(c, -1);
    wdat[0] = 64'hDEAD; wdat[1] = 64'hBEEF;
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    wr_burst(c, -1);
    rd_burst(mk(5, BASE, 1, 3, 1), -1);
    rd_burst(mk(4, BASE - 16, 1, 3, 1), -1);
    c = mk(9, BASE + u64'(DEPTH - 1) * 8, 1, 3, 1);
    wr_burst(c, -1);
    rd_burst(c, -1);
    c = mk(10, BASE + 8 * 50, 1, 4, 1);
    wr_burst(c, -1);
    rd_burst(c, -1);
    rd_burst(mk(10, BASE + 8 * 50, 3, 3, 1), -1);
    c = mk(11, BASE + 8 * 60, 2, 3, 1);
    for (int i = 0; i < 3; i++) begin
      wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF;
    end
    wr_burst(c, 1);
    rd_burst(c, -1);
  endtask

  task automatic test_back_to_back;
    aw_chan_t c;
    int len, sz, bt, st;
    u64 off;
    for (int it = 0; it < 25; it++) begin
      bt = $urandom_range(0, 2);
      sz = $urandom_range(0, 3);
      if (bt == 2) len = (2 << $urandom_range(0, 2)) - 1;
      else len = $urandom_range(0, 15);
      off = u64'($urandom_range(0, 1500));
      off = off & ~((u64'(1) << sz) - 1);
      c = mk($urandom_range(0, 15), BASE + off, len, sz, bt);
      for (int i = 0; i <= len; i++) begin
        wdat[i] = {$urandom, $urandom}; wstb[i] = 8'($urandom);
      end
      wr_burst(c, -1);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      rd_burst(c, st);
    end
  endtask

  task automatic test_reset_mid;
    aw_chan_t c;
    logic [1:0] r;
    c = mk(12, BASE + 8 * 40, 7, 3, 1);
    for (int i = 0; i < 8; i++) begin
      wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF;
    end
    aw_hs(c);
    for (int i = 0; i < 3; i++) begin
      r = model_w(c, i);
      w_valid = 1;
      w_bits = '{data: wdat[i], strb: wstb[i], last: 1'b0};
      @(negedge clk);
    end
    w_bits.data = wdat[3];
    rst_n = 0;
    #1;
    check_idle_outputs("reset_mid");
    w_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rd_burst(c, -1);
    c = mk(13, BASE + 8 * 90, 3, 3, 1);
    wr_burst(c, -1);
    rd_burst(c, 2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_strobe;
    test_arb;
    test_wrap;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sy_axi_mem_slave.md
Name: sy_axi_mem_slave

Overview:
- AXI4 slave memory responder. It is the far end of the AXI4 master port driven by the L2 cache in the main-memory path.
- Serves one burst at a time, read or write, from an internal word-addressed array with byte strobes.
- Used as the simulation/FPGA backing store behind sy_main_mem, and as a standalone target for the L2 bench.

Parameters:
- MEM_DEPTH, 65536, number of 64-bit words in the array.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- DATA_WTH, 64, data width in bits; fixed to match axi_pkg.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- inp_axi_aw_valid_i  in  1  write address valid.
- inp_axi_aw_ready_o  out  1  write address ready.
- inp_axi_aw_bits_i  in  axi_pkg::aw_chan_t  write address channel; uses id, addr, len, size, burst.
- inp_axi_w_valid_i  in  1  write data valid.
- inp_axi_w_ready_o  out  1  write data ready.
- inp_axi_w_bits_i  in  axi_pkg::w_chan_t  write data channel; uses data, strb, last.
- inp_axi_b_valid_o  out  1  write response valid.
- inp_axi_b_ready_i  in  1  write response ready.
- inp_axi_b_bits_o  out  axi_pkg::b_chan_t  write response; carries id, resp.
- inp_axi_ar_valid_i  in  1  read address valid.
- inp_axi_ar_ready_o  out  1  read address ready.
- inp_axi_ar_bits_i  in  axi_pkg::ar_chan_t  read address channel; uses id, addr, len, size, burst.
- inp_axi_r_valid_o  out  1  read data valid.
- inp_axi_r_ready_i  in  1  read data ready.
- inp_axi_r_bits_o  out  axi_pkg::r_chan_t  read data; carries id, data, resp, last.

Behaviour:
- Reset (rst_i=0, async):
  - All valid/ready outputs go to 0; bits outputs go to 0.
  - FSM goes to IDLE; beat counter clears; rr_last clears to READ.
  - The memory array is not reset.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - aw_ready = grant_w; ar_ready = grant_r.
  - Only one valid → grant that channel.
  - Both valid → grant the channel opposite to rr_last. The first tie after reset goes to write.
  - On handshake, latch id, addr, len, size, burst; clear beat_cnt; set rr_last. Go to WR_DATA or RD_DATA.
- Address generation, per beat, with step = 1<<size:
  - FIXED (2'b00): address is constant.
  - INCR (2'b01): address += step.
  - WRAP (2'b10): address wraps within a (len+1)*step aligned window.
  - burst=2'b11 is treated as INCR.
  - Word index = (addr-BASE_ADDR)>>3.
- Error conditions:
  - Decode error: addr<BASE_ADDR or word index ≥MEM_DEPTH, checked per beat → that beat is DECERR (2'b11). Writes are dropped; reads return data 0.
  - size>3 → SLVERR (2'b10) for every beat; no array access.
- WR_DATA:
  - w_ready=1.
  - Each W handshake writes the bytes whose strb bit is set, then beat_cnt++.
  - The burst ends on the handshake where beat_cnt==len.
  - If w.last disagrees with (beat_cnt==len) on any beat, set a sticky SLVERR for the burst.
  - W beats beyond len are never accepted in this state.
  - Go to WR_RESP.
- WR_RESP:
  - b_valid=1 the cycle after the last W handshake.
  - b.id = latched id.
  - b.resp = worst error seen in the burst (DECERR > SLVERR > OKAY).
  - Hold until b_ready, then go to IDLE.
- RD_DATA:
  - Array read is registered. r_valid rises 1 cycle after the AR handshake.
  - r.data, resp, id, last are stable while r_valid && !r_ready.
  - r.last=1 on beat len.
  - With r_ready held high, beats issue back-to-back at 1 per cycle (next beat prefetched on handshake).
  - After the last handshake, go to IDLE; r_valid=0 the next cycle.
- Write ordering: a read of an address in the cycle after its B handshake returns the new data; no bypass is needed beyond the registered array.
- Throughput: at least 1 idle cycle between bursts (the IDLE grant cycle). len up to 255 is supported.
- Reset mid-burst: the burst is abandoned with no response; the array keeps the beats already written.

Test Plan:
- Reset, then AW{id=3, addr=0x8000_0000, len=3, size=3, INCR} plus 4 W beats 0x11..0x44 with strb=FF → B{id=3, resp=OKAY} 1 cycle after the last W. A following AR with the same fields → R beats 0x11,0x22,0x33,0x44, r.last only on the 4th, first r_valid 1 cycle after AR.
- Partial strobe: write 0xAABBCCDD_EEFF0011 with strb=0x0F over all-zero memory → readback 0x00000000_EEFF0011.
- AW and AR asserted together from reset → write granted first. Re-assert both → read granted. Alternation continues.
- WRAP: len=3, size=3, addr=0x8000_0018 → beats read words at offsets 0x18,0x00,0x08,0x10.
- Decode error: AR at addr=BASE_ADDR+MEM_DEPTH*8, len=1 → 2 beats, data 0, resp=DECERR. An AW to the same address → B resp=DECERR and the array is unchanged.
- r_ready held low for 5 cycles mid-burst → r bits stable, no beat lost. Assert rst_i=0 mid write burst → all valids/readies 0 immediately; next transaction completes OKAY.
